// File: rtl/nios2_small_oci_dct_pkg.sv
// Shared constants and FSM encoding for the OCI trace (DCT) capture controller.
package nios2_small_oci_dct_pkg;
  localparam int FRAME_W         = 10;
  localparam int FRAMES_PER_WORD = 3;
  localparam int DCT_W           = FRAME_W * FRAMES_PER_WORD;
  localparam int DCT_CNT_W       = 4;
  localparam int ADDR_W          = 7;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_FLUSH_WR = 2'd2,
    ST_DONE     = 2'd3
  } dct_state_e;
endpackage

// File: rtl/nios2_small_nios2_qsys_oci_dct_ctrl_if.sv
// Trace-port, trace-RAM and status bundle of the DCT capture controller.
interface nios2_small_nios2_qsys_oci_dct_ctrl_if;
  import nios2_small_oci_dct_pkg::*;

  logic                 trc_on;
  logic                 frame_valid;
  logic [FRAME_W-1:0]   frame_data;
  logic                 frame_ready;
  logic                 wrap_en;
  logic                 flush_req;
  logic                 tm_wr;
  logic [ADDR_W-1:0]    tm_addr;
  logic [DCT_W-1:0]     tm_data;
  logic                 tm_ack;
  logic                 flush_done;
  logic [DCT_W-1:0]     dct_buffer;
  logic [DCT_CNT_W-1:0] dct_count;
  logic                 tm_full;
  logic                 tm_wrapped;
  logic                 overflow;

  modport slave (
    input  trc_on, frame_valid, frame_data, wrap_en, flush_req, tm_ack,
    output frame_ready, tm_wr, tm_addr, tm_data, flush_done,
           dct_buffer, dct_count, tm_full, tm_wrapped, overflow
  );

  modport master (
    output trc_on, frame_valid, frame_data, wrap_en, flush_req, tm_ack,
    input  frame_ready, tm_wr, tm_addr, tm_data, flush_done,
           dct_buffer, dct_count, tm_full, tm_wrapped, overflow
  );
endinterface

// File: rtl/nios2_small_oci_dct_packer.sv
// Frame packer: newest frame enters the low slot, older frames shift upward.
module nios2_small_oci_dct_packer
  import nios2_small_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_accept,
  input  logic [FRAME_W-1:0]   i_frame,
  input  logic                 i_clear,
  output logic [DCT_W-1:0]     o_buffer,
  output logic [DCT_CNT_W-1:0] o_count
);
  logic [FRAME_W-1:0]   r_slot [FRAMES_PER_WORD];
  logic [DCT_CNT_W-1:0] r_count;

  genvar gi;
  generate
    for (gi = 0; gi < FRAMES_PER_WORD; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_slot[gi] <= '0;
        end else if (i_clear) begin
          r_slot[gi] <= '0;
        end else if (i_accept) begin
          if (gi == 0) r_slot[gi] <= i_frame;
          else         r_slot[gi] <= r_slot[(gi == 0) ? 0 : gi - 1];
        end
      end
      assign o_buffer[gi*FRAME_W +: FRAME_W] = r_slot[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_accept) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/nios2_small_nios2_qsys_oci_dct_ctrl.sv
// OCI trace capture: packs frames into DCT words and hands them to the trace RAM.
module nios2_small_nios2_qsys_oci_dct_ctrl
  import nios2_small_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset,
  nios2_small_nios2_qsys_oci_dct_ctrl_if.slave bus
);
  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(FRAMES_PER_WORD);

  dct_state_e           r_state;
  dct_state_e           w_state_next;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic                 r_flush_pending;
  logic                 r_tm_full;
  logic                 r_tm_wrapped;
  logic                 r_overflow;
  logic                 w_frame_ready;
  logic                 w_tm_wr;
  logic                 w_accept;
  logic                 w_ack;
  logic                 w_set_pending;
  logic [DCT_W-1:0]     w_dct_buffer;
  logic [DCT_CNT_W-1:0] w_dct_count;
  logic [DCT_CNT_W-1:0] w_count_after;

  // Ready is also gated by reset so nothing is offered while held in reset.
  assign w_frame_ready = (r_state == ST_FILL) & bus.trc_on & ~r_tm_full & ~reset;
  assign w_tm_wr       = (r_state == ST_WRITE) | (r_state == ST_FLUSH_WR);
  assign w_accept      = bus.frame_valid & w_frame_ready;
  assign w_ack         = w_tm_wr & bus.tm_ack;
  assign w_count_after = w_dct_count + {{(DCT_CNT_W-1){1'b0}}, w_accept};

  nios2_small_oci_dct_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_accept (w_accept),
    .i_frame  (bus.frame_data),
    .i_clear  (w_ack),
    .o_buffer (w_dct_buffer),
    .o_count  (w_dct_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: begin
        if (bus.flush_req) begin
          // A full RAM only acknowledges the flush; the buffer is kept.
          if (r_tm_full)                   w_state_next = ST_DONE;
          else if (w_count_after == FULL_CNT) w_state_next = ST_WRITE;
          else if (w_count_after != '0)    w_state_next = ST_FLUSH_WR;
          else                             w_state_next = ST_DONE;
        end else if (w_accept && w_count_after == FULL_CNT) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_ack) w_state_next = (r_flush_pending | bus.flush_req) ? ST_DONE : ST_FILL;
      end
      ST_FLUSH_WR: begin
        if (w_ack) w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_FILL;
      default:  w_state_next = ST_FILL;
    endcase
  end

  always_comb begin
    bus.frame_ready = w_frame_ready;
    bus.tm_wr       = w_tm_wr;
    bus.tm_addr     = r_wr_ptr;
    bus.tm_data     = w_tm_wr ? w_dct_buffer : '0;
    bus.flush_done  = (r_state == ST_DONE);
    bus.dct_buffer  = w_dct_buffer;
    bus.dct_count   = w_dct_count;
    bus.tm_full     = r_tm_full;
    bus.tm_wrapped  = r_tm_wrapped;
    bus.overflow    = r_overflow;
  end

  // A flush that lands while a full word is being written completes after that write.
  assign w_set_pending = bus.flush_req &
                         (((r_state == ST_FILL) & ~r_tm_full & (w_count_after == FULL_CNT)) |
                          ((r_state == ST_WRITE) & ~w_ack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_flush_pending <= 1'b0;
      r_tm_full       <= 1'b0;
      r_tm_wrapped    <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      if (w_ack) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == '1) begin
          if (bus.wrap_en) r_tm_wrapped <= 1'b1;
          else             r_tm_full    <= 1'b1;
        end
      end
      if (r_state == ST_DONE)  r_flush_pending <= 1'b0;
      else if (w_set_pending)  r_flush_pending <= 1'b1;
      if (bus.frame_valid & bus.trc_on & r_tm_full) r_overflow <= 1'b1;
    end
  end
endmodule
